// File: rtl/img_ctrl_pkg.sv
// Shared types and widths for the pixel scan controller and its skid FIFO.
package img_ctrl_pkg;

  localparam int PIX_W   = 24;
  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } pix_tag_t;

  // FIFO entry layout: {data, tag}, tag occupies the low bits.
  localparam int TAG_W    = $bits(pix_tag_t);
  localparam int DATA_OFS = TAG_W;
  localparam int ENTRY_W  = PIX_W + TAG_W;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding tagged pixels; push and pop may share a cycle, flush empties it.
module pix_skid_fifo
  import img_ctrl_pkg::*;
#(
  parameter int DATA_W = ENTRY_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Raster frame sequencer: issues one pixel read per pixel and streams tagged pixels out.
// Define IMG_ROTATE_EN for 90-degree clockwise rotation of destination coordinates.
module pixel_scan_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int MAX_W  = 768,
  parameter int MAX_H  = 512,
  parameter int ADDR_W = 19
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_data,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic               out_last,
  output logic [COORD_W-1:0] out_width,
  output logic [COORD_W-1:0] out_height
);

  localparam logic [COORD_W-1:0] MAX_W_C = COORD_W'(MAX_W);
  localparam logic [COORD_W-1:0] MAX_H_C = COORD_W'(MAX_H);
  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] width_q, height_q, row_q, col_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               inflight_q;
  pix_tag_t           inflight_tag_q;
  logic               done_q, cfg_err_q;

  logic               dims_ok, start_ok, abort_now, xfer, last_rd, last_xfer;
  logic [1:0]         fifo_cnt;
  logic [ENTRY_W-1:0] fifo_head;
  pix_tag_t           head_tag, issue_tag;

  assign dims_ok   = (cfg_width != '0) && (cfg_width <= MAX_W_C) &&
                     (cfg_height != '0) && (cfg_height <= MAX_H_C);
  assign start_ok  = (state_q == S_IDLE) && start && dims_ok;
  assign abort_now = (state_q != S_IDLE) && abort;
  assign xfer      = out_valid && out_ready;
  assign last_rd   = (row_q == height_q - ONE) && (col_q == width_q - ONE);
  assign head_tag  = fifo_head[TAG_W-1:0];
  assign last_xfer = xfer && head_tag.last;

  // Credit: at most two pixels between issue and hand-off, refilled by each transfer.
  assign rd_en = (state_q == S_RUN) &&
                 (((fifo_cnt + {1'b0, inflight_q}) < 2'd2) || xfer);

  always_comb begin
    issue_tag      = '0;
    issue_tag.last = last_rd;
`ifdef IMG_ROTATE_EN
    issue_tag.row  = col_q;
    issue_tag.col  = height_q - ONE - row_q;
`else
    issue_tag.row  = row_q;
    issue_tag.col  = col_q;
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                 state_d = S_IDLE;
        else if (rd_en && last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: if (abort || last_xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      width_q        <= '0;
      height_q       <= '0;
      row_q          <= '0;
      col_q          <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      done_q     <= (state_q == S_DRAIN) && last_xfer && !abort;
      cfg_err_q  <= (state_q == S_IDLE) && start && !dims_ok;
      inflight_q <= rd_en && !abort;
      if (rd_en) inflight_tag_q <= issue_tag;
      if (start_ok) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        row_q    <= '0;
        col_q    <= '0;
        addr_q   <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (col_q == width_q - ONE) begin
          col_q <= '0;
          row_q <= row_q + ONE;
        end else begin
          col_q <= col_q + ONE;
        end
      end
    end
  end

  pix_skid_fifo #(.DATA_W(ENTRY_W)) u_fifo (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .flush_i    (abort_now),
    .push_i     (inflight_q),
    .push_data_i({rd_data, inflight_tag_q}),
    .pop_i      (xfer),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign rd_addr   = addr_q;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_head[DATA_OFS +: PIX_W];
  assign out_row   = head_tag.row;
  assign out_col   = head_tag.col;
  assign out_last  = head_tag.last;
`ifdef IMG_ROTATE_EN
  assign out_width  = height_q;
  assign out_height = width_q;
`else
  assign out_width  = width_q;
  assign out_height = height_q;
`endif

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Bench for pixel_scan_ctrl: random frames and backpressure against a raster-order pixel model.
// Honours IMG_ROTATE_EN the same way as the design.
module tb_pixel_scan_ctrl;

  localparam int AW = 19;

  typedef struct packed {
    logic [23:0] data;
    logic [10:0] row;
    logic [10:0] col;
    logic        last;
  } pix_t;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [10:0]   cfg_width = '0;
  logic [10:0]   cfg_height = '0;
  logic          busy, done, cfg_err, rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [23:0]   out_data;
  logic [10:0]   out_row, out_col, out_width, out_height;
  logic          out_last;

  pixel_scan_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_width(out_width), .out_height(out_height)
  );

  always #5 HCLK = ~HCLK;

  int            testCount = 0;
  int            failCount = 0;
  logic [23:0]   mem [4096];
  pix_t          expQ[$];
  int            cyc = 0;
  int            readIdx, xferCnt, doneCnt, errCnt, maxOcc;
  int            firstRdCyc, lastRdCyc, firstValidCyc, lastXferCyc, doneCyc, startCyc;
  int            readyMode = 0;
  int            expW, expH;
  logic          pendRead = 1'b0;
  logic [AW-1:0] pendAddr = '0;
  logic          prevStall = 1'b0;
  pix_t          prevOut;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Expected stream: every source pixel in raster order, mapped to its destination.
  task automatic buildModel(input int w, input int h);
    pix_t e;
    expQ.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        mem[r*w + c] = 24'($urandom);
        e.data = mem[r*w + c];
`ifdef IMG_ROTATE_EN
        e.row = 11'(c);
        e.col = 11'(h - 1 - r);
`else
        e.row = 11'(r);
        e.col = 11'(c);
`endif
        e.last = (r == h - 1) && (c == w - 1);
        expQ.push_back(e);
      end
    end
`ifdef IMG_ROTATE_EN
    expW = h; expH = w;
`else
    expW = w; expH = h;
`endif
  endtask

  task automatic clearStats();
    readIdx = 0; xferCnt = 0; doneCnt = 0; errCnt = 0; maxOcc = 0;
    firstRdCyc = -1; lastRdCyc = -1; firstValidCyc = -1; lastXferCyc = -1; doneCyc = -1;
    prevStall = 1'b0;
  endtask

  task automatic monitor();
    pix_t e;
    pix_t cur;
    cur = '{data: out_data, row: out_row, col: out_col, last: out_last};
    if (prevStall) checkOutput("hold_stable", 64'({out_valid, cur}), 64'({1'b1, prevOut}));
    if (rd_en) begin
      checkOutput("rd_addr", 64'(rd_addr), 64'(readIdx));
      if (firstRdCyc < 0) firstRdCyc = cyc;
      lastRdCyc = cyc;
      readIdx++;
      pendRead = 1'b1;
      pendAddr = rd_addr;
    end else begin
      pendRead = 1'b0;
    end
    if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("extra_transfer", 64'(1), 64'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("pixel", 64'(cur), 64'(e));
      end
      xferCnt++;
      lastXferCyc = cyc;
    end
    if (readIdx - xferCnt > maxOcc) maxOcc = readIdx - xferCnt;
    prevStall = out_valid && !out_ready;
    prevOut = cur;
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
      checkOutput("busy_at_done", 64'(busy), 64'(0));
    end
    if (cfg_err) errCnt++;
  endtask

  task automatic runCycle();
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    @(negedge HCLK);
    monitor();
    @(posedge HCLK);
    #1;
    rd_data = pendRead ? mem[pendAddr[11:0]] : 24'($urandom);
    cyc++;
  endtask

  task automatic applyStimulus(input int w, input int h);
    buildModel(w, h);
    clearStats();
    cfg_width = 11'(w);
    cfg_height = 11'(h);
    start = 1'b1;
    startCyc = cyc;
    runCycle();
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    checkOutput("out_width", 64'(out_width), 64'(expW));
    checkOutput("out_height", 64'(out_height), 64'(expH));
  endtask

  task automatic finishFrame(input int w, input int h, input bit timing);
    int n;
    n = 0;
    while (doneCnt == 0 && n < w*h*4 + 40) begin
      runCycle();
      n++;
    end
    if (doneCnt == 0) checkOutput("done_timeout", 64'(0), 64'(1));
    checkOutput("transfers", 64'(xferCnt), 64'(w*h));
    checkOutput("model_left", 64'(expQ.size()), 64'(0));
    checkOutput("done_latency", 64'(doneCyc), 64'(lastXferCyc + 1));
    checkOutput("occupancy_le2", 64'(maxOcc <= 2), 64'(1));
    if (timing) begin
      checkOutput("first_rd", 64'(firstRdCyc), 64'(startCyc + 1));
      checkOutput("rd_burst", 64'(lastRdCyc - firstRdCyc), 64'(w*h - 1));
      checkOutput("first_valid", 64'(firstValidCyc), 64'(firstRdCyc + 2));
      checkOutput("xfer_burst", 64'(lastXferCyc - firstValidCyc), 64'(w*h - 1));
    end
    runCycle();
    runCycle();
    checkOutput("done_once", 64'(doneCnt), 64'(1));
    checkOutput("reads", 64'(readIdx), 64'(w*h));
  endtask

  task automatic startBad(input int w, input int h);
    clearStats();
    cfg_width = 11'(w);
    cfg_height = 11'(h);
    start = 1'b1;
    runCycle();
    start = 1'b0;
    checkOutput("cfg_err_pulse", 64'(cfg_err), 64'(1));
    checkOutput("cfg_err_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) runCycle();
    checkOutput("cfg_err_once", 64'(errCnt), 64'(1));
    checkOutput("cfg_err_no_rd", 64'(readIdx), 64'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"},
                64'({busy, done, cfg_err, rd_en, rd_addr, out_valid, out_width, out_height}), 64'(0));
    checkOutput({tag, "_data"}, 64'({out_data, out_row, out_col, out_last}), 64'(0));
  endtask

  initial begin
    int w, h, n;
    clearStats();
    for (int i = 0; i < 3; i++) runCycle();
    checkAllZero("reset");
    HRESETn = 1'b1;
    runCycle();

    readyMode = 0;
    applyStimulus(4, 3);
    finishFrame(4, 3, 1'b1);

    readyMode = 1;
    out_ready = 1'b0;
    applyStimulus(4, 3);
    for (int i = 0; i < 3; i++) runCycle();
    cfg_width = 11'd2;
    cfg_height = 11'd2;
    start = 1'b1;
    runCycle();
    start = 1'b0;
    checkOutput("width_stable", 64'(out_width), 64'(expW));
    finishFrame(4, 3, 1'b0);

    readyMode = 0;
    startBad(0, 3);
    startBad(769, 3);
    startBad(4, 0);
    startBad(4, 513);
    startBad(2047, 2047);

    applyStimulus(4, 3);
    n = 0;
    while (xferCnt < 5 && n < 100) begin
      runCycle();
      n++;
    end
    checkOutput("abort_setup", 64'(xferCnt), 64'(5));
    readyMode = 3;
    out_ready = 1'b0;
    runCycle();
    runCycle();
    abort = 1'b1;
    runCycle();
    abort = 1'b0;
    prevStall = 1'b0;
    checkOutput("abort_valid", 64'(out_valid), 64'(0));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_rd_en", 64'(rd_en), 64'(0));
    readyMode = 0;
    for (int i = 0; i < 4; i++) runCycle();
    checkOutput("abort_no_done", 64'(doneCnt), 64'(0));
    checkOutput("abort_no_xfer", 64'(xferCnt), 64'(5));
    applyStimulus(4, 3);
    finishFrame(4, 3, 1'b1);

    readyMode = 2;
    applyStimulus(6, 4);
    for (int i = 0; i < 7; i++) runCycle();
    HRESETn = 1'b0;
    runCycle();
    checkAllZero("midreset");
    HRESETn = 1'b1;
    prevStall = 1'b0;
    readyMode = 0;
    runCycle();
    checkOutput("midreset_idle", 64'(busy), 64'(0));
    applyStimulus(5, 2);
    finishFrame(5, 2, 1'b1);

    applyStimulus(768, 1);
    finishFrame(768, 1, 1'b1);
    applyStimulus(1, 1);
    finishFrame(1, 1, 1'b1);
    readyMode = 2;
    applyStimulus(1, 512);
    finishFrame(1, 512, 1'b0);

    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(1, 24);
      h = $urandom_range(1, 12);
      applyStimulus(w, h);
      finishFrame(w, h, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
